game_session_ctrl: RTL and testbench

GAME_SESSION_CTRL -- requirements
Module: game_session_ctrl

---
 rtl/game_session_if.sv | 46 ++++
 rtl/game_session_ctrl.sv | 137 +++++++++++++
 tb/tb_game_session_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/game_session_if.sv
`default_nettype none
// ============================================================================
//  Module      : game_session_if
//  Description : Bundles the player-facing signals of the game session
//                controller. The controller connects through the slave
//                modport. The environment or testbench that drives the
//                button and point inputs connects through the master modport.
//  Signals     : start_btn   - raw asynchronous start pushbutton level
//                point_in    - one-cycle clk-synchronous point pulse
//                game_start  - high while a round is in progress
//                game_finish - high while the round-over screen is shown
//                win         - round result, valid while game_finish is high
//                score       - points scored in the current or last round
//                secs_left   - whole seconds remaining in the round
//  Revision    : 1.0 - initial release
// ============================================================================
interface game_session_if;
  logic       start_btn;
  logic       point_in;
  logic       game_start;
  logic       game_finish;
  logic       win;
  logic [7:0] score;
  logic [7:0] secs_left;

  modport slave (
    input  start_btn,
    input  point_in,
    output game_start,
    output game_finish,
    output win,
    output score,
    output secs_left
  );

  modport master (
    output start_btn,
    output point_in,
    input  game_start,
    input  game_finish,
    input  win,
    input  score,
    input  secs_left
  );
endinterface
`default_nettype wire

// File: rtl/game_session_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : game_session_ctrl
//  Description : Controls one timed game round. The start button is
//                synchronised and edge-detected. A round runs for
//                GAME_SECONDS seconds or until WIN_SCORE points are scored,
//                whichever comes first. The round-over screen then holds the
//                result until the next start press.
//  Ports       : clk   - system clock, rising edge
//                rst_n - asynchronous active-low reset
//                bus   - game_session_if.slave (start_btn, point_in in;
//                        game_start, game_finish, win, score, secs_left out)
//  Revision    : 1.0 - initial release
// ============================================================================
module game_session_ctrl #(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int GAME_SECONDS  = 30,
  parameter int WIN_SCORE     = 10
) (
  input  wire                  clk,
  input  wire                  rst_n,
  game_session_if.slave        bus
);

  localparam int               c_TICK_W    = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [c_TICK_W-1:0] c_TICK_MAX = c_TICK_W'(TICKS_PER_SEC - 1);
  localparam logic [7:0]       c_GAME_SECS = 8'(GAME_SECONDS);
  localparam logic [7:0]       c_WIN_SCORE = 8'(WIN_SCORE);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAYING = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_sync1;
  logic                r_sync2;
  logic                r_sync_d;      // previous synchronised level, for edge detection
  logic [c_TICK_W-1:0] r_tick;
  logic [7:0]          r_score;
  logic [7:0]          r_secs_left;
  logic                r_win;
  logic                r_game_start;
  logic                r_game_finish;

  logic                w_start_evt;
  logic                w_wrap;
  logic                w_last_wrap;
  logic [7:0]          w_score_inc;
  logic [7:0]          w_score_next;
  logic                w_point_win;

  always_comb begin
    w_start_evt  = r_sync2 & ~r_sync_d;
    w_wrap       = (r_tick == c_TICK_MAX);
    // The wrap that takes secs_left from 1 to 0 is the one that ends the round.
    w_last_wrap  = w_wrap && (r_secs_left == 8'd1);
    w_score_inc  = (r_score == 8'hFF) ? 8'hFF : (r_score + 8'd1);
    w_score_next = bus.point_in ? w_score_inc : r_score;
    w_point_win  = bus.point_in && (w_score_inc == c_WIN_SCORE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_sync1       <= 1'b0;
      r_sync2       <= 1'b0;
      r_sync_d      <= 1'b0;
      r_tick        <= '0;
      r_score       <= 8'd0;
      r_secs_left   <= 8'd0;
      r_win         <= 1'b0;
      r_game_start  <= 1'b0;
      r_game_finish <= 1'b0;
    end else begin
      r_sync1  <= bus.start_btn;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;

      case (r_state)
        ST_IDLE: begin
          if (w_start_evt) begin
            r_state       <= ST_PLAYING;
            r_game_start  <= 1'b1;
            r_game_finish <= 1'b0;
            r_score       <= 8'd0;
            r_secs_left   <= c_GAME_SECS;
            r_tick        <= '0;
            r_win         <= 1'b0;
          end
        end

        ST_PLAYING: begin
          r_tick <= w_wrap ? '0 : (r_tick + 1'b1);
          if (w_wrap && (r_secs_left != 8'd0)) begin
            r_secs_left <= r_secs_left - 8'd1;
          end
          if (bus.point_in) begin
            r_score <= w_score_inc;
          end
          // A winning point and the final wrap may land on the same edge.
          // Both effects above still apply, and only one transition happens.
          if (w_point_win || w_last_wrap) begin
            r_state       <= ST_DONE;
            r_game_start  <= 1'b0;
            r_game_finish <= 1'b1;
            r_win         <= w_point_win || (w_score_next >= c_WIN_SCORE);
          end
        end

        ST_DONE: begin
          // Score, secs_left and win are held here. They stay held into
          // IDLE until the next round clears them.
          if (w_start_evt) begin
            r_state       <= ST_IDLE;
            r_game_finish <= 1'b0;
          end
        end

        default: begin
          r_state       <= ST_IDLE;
          r_game_start  <= 1'b0;
          r_game_finish <= 1'b0;
        end
      endcase
    end
  end

  assign bus.game_start  = r_game_start;
  assign bus.game_finish = r_game_finish;
  assign bus.win         = r_win;
  assign bus.score       = r_score;
  assign bus.secs_left   = r_secs_left;

endmodule
`default_nettype wire

// File: tb/tb_game_session_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_session_ctrl
//  Description : Directed self-checking bench for game_session_ctrl, with
//                TICKS_PER_SEC=4, GAME_SECONDS=3 and WIN_SCORE=5.
//                Inputs change 1 time unit after a rising edge, and outputs
//                are checked at that same point. Edge N counts from the first
//                edge that samples start_btn high.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_game_session_ctrl;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   done_entries;
  logic r_prev_finish;
  logic [7:0] secs_at_win;

  game_session_if bus ();

  game_session_ctrl #(
    .TICKS_PER_SEC (4),
    .GAME_SECONDS  (3),
    .WIN_SCORE     (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic gs, input logic gf,
                            input logic w, input logic [7:0] sc, input logic [7:0] sl);
    check({tag, ".game_start"},  {31'd0, bus.game_start},  {31'd0, gs});
    check({tag, ".game_finish"}, {31'd0, bus.game_finish}, {31'd0, gf});
    check({tag, ".win"},         {31'd0, bus.win},         {31'd0, w});
    check({tag, ".score"},       {24'd0, bus.score},       {24'd0, sc});
    check({tag, ".secs_left"},   {24'd0, bus.secs_left},   {24'd0, sl});
  endtask

  // game_start and game_finish must never be high together. Also count DONE entries.
  always @(negedge clk) begin
    if (rst_n) begin
      n_tests++;
      assert (!(bus.game_start && bus.game_finish)) else begin
        n_fail++;
        $error("FAIL invariant: observed gs=%0b gf=%0b expected not both 1",
               bus.game_start, bus.game_finish);
      end
      if (bus.game_finish && !r_prev_finish) done_entries++;
    end
    r_prev_finish = bus.game_finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0; n_fail = 0; done_entries = 0; r_prev_finish = 1'b0;
    rst_n = 1'b0;
    bus.start_btn = 1'b0;
    bus.point_in  = 1'b0;

    // Reset state
    step(2);
    check_outs("reset", 0, 0, 0, 8'd0, 8'd0);
    #3 rst_n = 1'b1;
    step(1);

    // Timeout round, no points
    bus.start_btn = 1'b1;
    step(2);
    check("to.edge2_gs", {31'd0, bus.game_start}, 32'd0);
    step(1);
    check_outs("to.edge3", 1, 0, 0, 8'd0, 8'd3);
    bus.start_btn = 1'b0;
    step(3);                                    // edge 6, tick 3
    check("to.edge6_secs", {24'd0, bus.secs_left}, 32'd3);
    step(1);                                    // edge 7, first wrap
    check("to.edge7_secs", {24'd0, bus.secs_left}, 32'd2);
    step(4);                                    // edge 11
    check("to.edge11_secs", {24'd0, bus.secs_left}, 32'd1);
    step(3);                                    // edge 14, still playing
    check("to.edge14_gs", {31'd0, bus.game_start}, 32'd1);
    step(1);                                    // edge 15, 12 cycles after start
    check_outs("to.done", 0, 1, 0, 8'd0, 8'd0);

    // A press in DONE returns to IDLE with the result held
    bus.start_btn = 1'b1;
    step(3);
    bus.start_btn = 1'b0;
    check_outs("done2idle", 0, 0, 0, 8'd0, 8'd0);
    step(2);

    // Button held 20 cycles: a single start event gives a single round
    bus.start_btn = 1'b1;
    step(3);
    check_outs("hold.start", 1, 0, 0, 8'd0, 8'd3);
    step(17);                                   // edge 20: timed out at edge 15, no restart
    check_outs("hold.edge20", 0, 1, 0, 8'd0, 8'd0);
    bus.start_btn = 1'b0;
    step(3);
    check("hold.still_done", {31'd0, bus.game_finish}, 32'd1);
    bus.start_btn = 1'b1;
    step(3);
    bus.start_btn = 1'b0;
    check("hold.to_idle", {31'd0, bus.game_finish}, 32'd0);
    step(2);

    // Early win: 5 consecutive points sampled on edges 4..8. The wrap at
    // edge 7 drops secs_left to 2 before the win, then secs_left freezes.
    bus.start_btn = 1'b1;
    step(3);
    bus.start_btn = 1'b0;
    check_outs("win.start", 1, 0, 0, 8'd0, 8'd3);
    bus.point_in = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step(1);
      check($sformatf("win.score%0d", k), {24'd0, bus.score}, k);
      check($sformatf("win.gs%0d", k), {31'd0, bus.game_start}, 32'd1);
    end
    step(1);
    bus.point_in = 1'b0;
    check_outs("win.done", 0, 1, 1, 8'd5, 8'd2);
    secs_at_win = bus.secs_left;
    bus.point_in = 1'b1;                        // points are ignored in DONE
    step(1);
    bus.point_in = 1'b0;
    step(6);
    check_outs("win.frozen", 0, 1, 1, 8'd5, secs_at_win);
    bus.start_btn = 1'b1;
    step(3);
    bus.start_btn = 1'b0;
    check_outs("win.idle_hold", 0, 0, 1, 8'd5, 8'd2);
    bus.point_in = 1'b1;                        // points are ignored in IDLE
    step(1);
    bus.point_in = 1'b0;
    step(1);
    check("idle.point_ignored", {24'd0, bus.score}, 32'd5);

    // A press during PLAYING is ignored, then a point lands on the final wrap
    bus.start_btn = 1'b1;
    step(3);                                    // edge 3
    bus.start_btn = 1'b0;
    check_outs("sim.start", 1, 0, 0, 8'd0, 8'd3);
    step(2);                                    // edge 5
    bus.start_btn = 1'b1;
    step(4);                                    // edge 9, start_evt seen at edge 8
    bus.start_btn = 1'b0;
    check_outs("play.press_ignored", 1, 0, 0, 8'd0, 8'd2);
    bus.point_in = 1'b1;
    step(4);                                    // points on edges 10..13, wrap at edge 11
    bus.point_in = 1'b0;
    check_outs("sim.edge13", 1, 0, 0, 8'd4, 8'd1);
    step(1);                                    // edge 14
    check_outs("sim.edge14", 1, 0, 0, 8'd4, 8'd1);
    bus.point_in = 1'b1;
    step(1);                                    // edge 15: final wrap plus point
    bus.point_in = 1'b0;
    check_outs("sim.done", 0, 1, 1, 8'd5, 8'd0);
    step(2);
    check_outs("sim.hold", 0, 1, 1, 8'd5, 8'd0);
    check("done_entries", done_entries, 32'd4);
    bus.start_btn = 1'b1;
    step(3);
    bus.start_btn = 1'b0;
    step(2);

    // Asynchronous reset mid-round with score 2
    bus.start_btn = 1'b1;
    step(3);
    bus.start_btn = 1'b0;
    bus.point_in = 1'b1;
    step(2);
    bus.point_in = 1'b0;
    check_outs("rst.pre", 1, 0, 0, 8'd2, 8'd3);
    #2 rst_n = 1'b0;
    #1;                                         // between edges, no clock has occurred
    check_outs("rst.async", 0, 0, 0, 8'd0, 8'd0);
    #3 rst_n = 1'b1;
    step(6);
    check_outs("rst.idle_wait", 0, 0, 0, 8'd0, 8'd0);
    check("rst.no_done", done_entries, 32'd4);

    // A button already held when reset releases gives exactly one start
    bus.start_btn = 1'b1;
    #2 rst_n = 1'b0;
    #4 rst_n = 1'b1;
    step(2);
    check("held_rel.edge2", {31'd0, bus.game_start}, 32'd0);
    step(1);
    check_outs("held_rel.edge3", 1, 0, 0, 8'd0, 8'd3);
    bus.start_btn = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
